// File: rtl/stream_mux_rr_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer slice.
package stream_mux_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_t;

   // Width of a channel index; a single-bit field is kept even for tiny N.
   function automatic int ch_idx_w(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the merger and one consumer.
// The master view is the surrounding system, the slave view is the merger.
interface stream_mux_rr_if
   import stream_mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 4
) ();

   localparam int CW = ch_idx_w(N_CH);

   logic [N_CH-1:0]        up_valid;
   logic [N_CH-1:0][W-1:0] up_data;
   logic [N_CH-1:0]        up_ready;
   logic                   down_valid;
   logic [W-1:0]           down_data;
   logic [CW-1:0]          down_chan;
   logic                   down_ready;

   modport master (
      output up_valid,
      output up_data,
      output down_ready,
      input  up_ready,
      input  down_valid,
      input  down_data,
      input  down_chan
   );

   modport slave (
      input  up_valid,
      input  up_data,
      input  down_ready,
      output up_ready,
      output down_valid,
      output down_data,
      output down_chan
   );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Request arbiter: one-hot grant plus its index, round-robin or fixed priority.
// The priority pointer only moves when the parent reports an accepted word.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int        N_CH     = 4,
   parameter arb_mode_t ARB_MODE = ARB_RR,
   localparam int       CW       = ch_idx_w(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] req,
   input  logic            advance,
   output logic [N_CH-1:0] grant,
   output logic [CW-1:0]   grant_idx
);

   logic [CW-1:0] ptr;

   // Scan requesters starting at the pointer, wrapping, and take the first one.
   always_comb begin
      int  idx;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int off = 0; off < N_CH; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N_CH) begin
            idx = idx - N_CH;
         end
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = CW'(idx);
         end
      end
   end

   // Move priority to the channel after the one just served; fixed mode keeps it at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (ARB_MODE == ARB_RR && advance) begin
         ptr <= (grant_idx == CW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream merger with valid/ready on every channel and a registered output.
// The output word carries the index of the channel it was taken from.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int        N_CH     = 4,
   parameter int        W        = 4,
   parameter arb_mode_t ARB_MODE = ARB_RR
) (
   input logic           clk,
   input logic           rst,
   stream_mux_rr_if.slave bus
);

   localparam int CW = ch_idx_w(N_CH);

   logic [N_CH-1:0] grant;
   logic [CW-1:0]   grant_idx;
   logic            any_grant;
   logic            load;
   logic            advance;
   logic            dv;
   logic [W-1:0]    dd;
   logic [CW-1:0]   dc;

   // The register can take a word when it is empty or being drained this cycle.
   assign load      = !dv || bus.down_ready;
   assign any_grant = |grant;
   assign advance   = any_grant && load && !rst;

   assign bus.up_ready   = (load && !rst) ? grant : '0;
   assign bus.down_valid = dv;
   assign bus.down_data  = dd;
   assign bus.down_chan  = dc;

   rr_arbiter #(
      .N_CH     (N_CH),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (bus.up_valid),
      .advance   (advance),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Output stage: capture the granted word, or go empty while keeping the last data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dv <= 1'b0;
         dd <= '0;
         dc <= '0;
      end else if (load) begin
         if (any_grant) begin
            dv <= 1'b1;
            dd <= bus.up_data[grant_idx];
            dc <= grant_idx;
         end else begin
            dv <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: one round-robin and one fixed-priority instance run in
// lockstep against a transaction-level model of arbitration and the output register.
module tb_stream_mux_rr;
   import stream_mux_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;

   int n_cmp = 0;
   int n_err = 0;

   logic [N-1:0] v   [2];
   logic [W-1:0] dat [2][N];
   logic         dr  [2];

   int           m_ptr [2];
   logic         m_dv  [2];
   logic [W-1:0] m_dd  [2];
   int           m_dc  [2];
   logic [N-1:0] acc   [2];

   always #5 clk = ~clk;

   stream_mux_rr_if #(.N_CH(N), .W(W)) bus_rr ();
   stream_mux_rr_if #(.N_CH(N), .W(W)) bus_fx ();

   stream_mux_rr #(.N_CH(N), .W(W), .ARB_MODE(ARB_RR)) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (bus_rr)
   );

   stream_mux_rr #(.N_CH(N), .W(W), .ARB_MODE(ARB_FIXED)) dut_fx (
      .clk (clk),
      .rst (rst),
      .bus (bus_fx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // First valid channel at or after 'start', going round modulo N; -1 when idle.
   function automatic int model_grant(input logic [N-1:0] valid, input int start);
      for (int k = 0; k < N; k++) begin
         if (valid[(start + k) % N]) begin
            return (start + k) % N;
         end
      end
      return -1;
   endfunction

   function automatic logic [31:0] obs_ready(input int d);
      return (d == 0) ? 32'(bus_rr.up_ready) : 32'(bus_fx.up_ready);
   endfunction
   function automatic logic [31:0] obs_dv(input int d);
      return (d == 0) ? 32'(bus_rr.down_valid) : 32'(bus_fx.down_valid);
   endfunction
   function automatic logic [31:0] obs_dd(input int d);
      return (d == 0) ? 32'(bus_rr.down_data) : 32'(bus_fx.down_data);
   endfunction
   function automatic logic [31:0] obs_dc(input int d);
      return (d == 0) ? 32'(bus_rr.down_chan) : 32'(bus_fx.down_chan);
   endfunction

   task automatic applyStimulus();
      bus_rr.up_valid   = v[0];
      bus_fx.up_valid   = v[1];
      bus_rr.down_ready = dr[0];
      bus_fx.down_ready = dr[1];
      for (int c = 0; c < N; c++) begin
         bus_rr.up_data[c] = dat[0][c];
         bus_fx.up_data[c] = dat[1][c];
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ptr[d] = 0;
         m_dv[d]  = 1'b0;
         m_dd[d]  = '0;
         m_dc[d]  = 0;
      end
   endtask

   task automatic set_valid(input logic [N-1:0] valid, input logic ready);
      for (int d = 0; d < 2; d++) begin
         v[d]  = valid;
         dr[d] = ready;
      end
   endtask

   task automatic set_data(input int c, input logic [W-1:0] value);
      dat[0][c] = value;
      dat[1][c] = value;
   endtask

   // While reset is high every output must read zero even with requests pending.
   task automatic checkOutput(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s d%0d up_ready", tag, d), obs_ready(d), 32'd0);
         chk($sformatf("%s d%0d down_valid", tag, d), obs_dv(d), 32'd0);
         chk($sformatf("%s d%0d down_data", tag, d), obs_dd(d), 32'd0);
         chk($sformatf("%s d%0d down_chan", tag, d), obs_dc(d), 32'd0);
      end
   endtask

   // One clock: check up_ready before the edge, advance the model, check down_* after.
   task automatic step();
      int   g  [2];
      logic ld [2];
      logic [N-1:0] er;
      applyStimulus();
      #1;
      for (int d = 0; d < 2; d++) begin
         ld[d] = !m_dv[d] || dr[d];
         g[d]  = model_grant(v[d], m_ptr[d]);
         er    = (g[d] >= 0 && ld[d]) ? N'(1 << g[d]) : '0;
         chk($sformatf("d%0d up_ready", d), obs_ready(d), 32'(er));
         acc[d] = er & v[d];
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (ld[d]) begin
            if (g[d] >= 0) begin
               m_dv[d] = 1'b1;
               m_dd[d] = dat[d][g[d]];
               m_dc[d] = g[d];
               if (d == 0) begin
                  m_ptr[d] = (g[d] + 1) % N;
               end
            end else begin
               m_dv[d] = 1'b0;
            end
         end
         chk($sformatf("d%0d down_valid", d), obs_dv(d), 32'(m_dv[d]));
         chk($sformatf("d%0d down_data", d), obs_dd(d), 32'(m_dd[d]));
         chk($sformatf("d%0d down_chan", d), obs_dc(d), 32'(m_dc[d]));
      end
   endtask

   initial begin
      int seq [6];
      seq = '{0, 1, 2, 3, 0, 1};

      rst = 1'b1;
      set_valid(4'b0000, 1'b1);
      for (int c = 0; c < N; c++) begin
         set_data(c, W'(8'h10 + c));
      end
      model_reset();
      applyStimulus();
      #12;
      set_valid(4'b1111, 1'b1);
      applyStimulus();
      #1;
      checkOutput("por");
      @(negedge clk);
      rst = 1'b0;

      // All channels busy: round-robin visits 0,1,2,3,0,1; fixed stays on ch0.
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rr_seq[%0d]", i), 32'(bus_rr.down_chan), 32'(seq[i]));
         chk($sformatf("fx_seq[%0d]", i), 32'(bus_fx.down_chan), 32'd0);
      end

      // Reset while a word is held: outputs clear at once, not at the next edge.
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst");
      model_reset();
      @(posedge clk);
      #1;
      checkOutput("mid_rst_edge");
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_rst first chan", 32'(bus_rr.down_chan), 32'd0);
      chk("post_rst first data", 32'(bus_rr.down_data), 32'h10);

      // Pointer wrap: steer ptr to 3, then ch3 and ch1 compete.
      set_valid(4'b0100, 1'b1);
      step();
      chk("wrap ptr=3", 32'(dut_rr.u_arb.ptr), 32'd3);
      set_valid(4'b1010, 1'b1);
      step();
      chk("wrap first ch3", 32'(bus_rr.down_chan), 32'd3);
      set_valid(4'b0010, 1'b1);
      step();
      chk("wrap then ch1", 32'(bus_rr.down_chan), 32'd1);
      chk("wrap ptr=2", 32'(dut_rr.u_arb.ptr), 32'd2);
      chk("fixed ptr held", 32'(dut_fx.u_arb.ptr), 32'd0);

      // Fixed priority: ch0 wins every time until it drops, then ch2 is served.
      set_data(0, 8'h20);
      set_data(2, 8'h22);
      set_valid(4'b0101, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("fx ch0 wins[%0d]", i), 32'(bus_fx.down_chan), 32'd0);
      end
      set_valid(4'b0100, 1'b1);
      step();
      chk("fx ch2 after drop", 32'(bus_fx.down_chan), 32'd2);
      chk("fx ch2 data", 32'(bus_fx.down_data), 32'h22);

      // Backpressure: hold a word from ch1 with data 0xA5 for five stalled cycles.
      set_data(1, 8'hA5);
      set_valid(4'b0010, 1'b1);
      step();
      set_valid(4'b0111, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp data[%0d]", i), 32'(bus_rr.down_data), 32'hA5);
         chk($sformatf("bp chan[%0d]", i), 32'(bus_rr.down_chan), 32'd1);
         chk($sformatf("bp ptr[%0d]", i), 32'(dut_rr.u_arb.ptr), 32'd2);
      end
      set_valid(4'b0111, 1'b1);
      step();
      chk("bp release rr chan", 32'(bus_rr.down_chan), 32'd2);
      chk("bp release fx chan", 32'(bus_fx.down_chan), 32'd0);

      // Idle gap: valid falls after the last word drains, data keeps its last value.
      set_valid(4'b0000, 1'b1);
      step();
      chk("idle valid", 32'(bus_rr.down_valid), 32'd0);
      chk("idle data hold", 32'(bus_rr.down_data), 32'h22);
      step();
      chk("idle valid 2", 32'(bus_rr.down_valid), 32'd0);

      // Random traffic: producers hold valid and data until their word is taken.
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
               if (!v[d][c] && ($urandom % 3 == 0)) begin
                  v[d][c]   = 1'b1;
                  dat[d][c] = W'($urandom);
               end
            end
            dr[d] = ($urandom % 4 != 0);
         end
         step();
         chk("rand ptr", 32'(dut_rr.u_arb.ptr), 32'(m_ptr[0]));
         for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
               if (acc[d][c]) begin
                  v[d][c]   = ($urandom % 2 == 0);
                  dat[d][c] = W'($urandom);
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes on every channel, a built-in arbiter (round-robin or fixed priority) and a registered output stage. It generalises the combinational 4:1 select mux into a backpressure-aware channel merger. It sits between several independent producers and a single consumer, and reports which channel each output word came from.

## Interface
- `N_CH`, default 4: number of input channels, ≥2.
- `W`, default 4: data width in bits, ≥1.
- `ARB_MODE`, default `ARB_RR`: arbitration mode, either `ARB_RR` (round-robin) or `ARB_FIXED` (lowest index wins).
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `up_valid` input, N_CH bits: per-channel valid.
- `up_data` input, N_CH×W bits (packed `[N_CH-1:0][W-1:0]`): per-channel data.
- `up_ready` output, N_CH bits: per-channel ready; at most one bit is high.
- `down_valid` output, 1 bit: output word valid.
- `down_data` output, W bits: output word.
- `down_chan` output, $clog2(N_CH) bits: source channel of `down_data`.
- `down_ready` input, 1 bit: consumer ready.

## Operation
- Transfer rules:
  - Upstream transfer on channel i: `up_valid[i] && up_ready[i]` at a rising edge.
  - Downstream transfer: `down_valid && down_ready`.
- Output register: `down_valid`, `down_data` and `down_chan` are flops. `load = !down_valid || down_ready`.
- Grant: a one-hot `grant` is computed combinationally from `up_valid` and the priority pointer. `up_ready[i] = grant[i] && load`. `grant` is 0 when no `up_valid` bit is set.
- On a load with a granted channel k:
  - `down_data <= up_data[k]`, `down_chan <= k`, `down_valid <= 1`.
- On a load with no request: `down_valid <= 0`. `down_data` and `down_chan` hold their values.
- `ARB_RR`:
  - The pointer `ptr` names the highest-priority channel.
  - The grant goes to the first requester at or after `ptr`, wrapping modulo N_CH.
  - After an upstream transfer from channel k, `ptr <= (k+1) mod N_CH`. Wrap-around: k = N_CH-1 gives `ptr` = 0.
  - `ptr` does not move unless a transfer happens.
- `ARB_FIXED`: the lowest-index requester wins. `ptr` is unused and held at 0.
- Starvation bound (RR): a channel that holds valid waits at most N_CH-1 transfers from other channels.
- Producer rule: once a producer raises `up_valid`, it keeps it high with stable data until accepted. The block never drops a word.
- Reset values (asynchronous, immediate): `down_valid` = 0, `down_data` = 0, `down_chan` = 0, `ptr` = 0. While `rst` is high, `up_ready` is forced to 0.
- Reset mid-operation: a word held in the output register is discarded. No upstream transfer is counted in a cycle where `rst` is high.

## Timing
- Latency: 1 cycle. A word accepted at edge t appears on `down_*` after edge t.
- Throughput: 1 word per cycle while `down_ready` = 1, with no bubble when switching channels.
- Backpressure: while `down_valid && !down_ready`:
  - `up_ready` = 0.
  - `down_*` are held stable.
  - `ptr` is frozen.
- Simultaneous events: when `down_ready` = 1 and a requester exists in the same cycle, the downstream word leaves and a new word loads at the same edge.
- Combinational paths:
  - `up_ready` depends on `up_valid`, `down_ready`, `down_valid` and `ptr`.
  - No path from `up_data` to any output.
  - No path from `down_ready` to `down_*`.

## Structure
- Shared package `stream_mux_pkg`:
  - Enum `arb_mode_t` with values `ARB_RR` and `ARB_FIXED`.
  - Function `ch_idx_w(n)` returning $clog2(n), floored at 1.
- Sub-module `rr_arbiter`:
  - Parameters: `N_CH`, `ARB_MODE`.
  - Inputs: `clk`, `rst`, `req`, `advance`.
  - Outputs: `grant` (one-hot), `grant_idx`.
  - Owns `ptr`.
- The top level instantiates `rr_arbiter`, builds the data select from `grant_idx` and holds the output register.

## Test plan
- Reset: assert `rst` mid-stream with `down_valid` = 1 → `down_valid`, `down_data`, `down_chan` all 0 immediately; after release, the first grant with all channels valid goes to ch0.
- RR fairness (N_CH = 4, W = 8, RR): all four channels valid continuously (ch_i data = 0x10+i), `down_ready` = 1 → `down_chan` sequence 0,1,2,3,0,1, one word per cycle.
- Pointer wrap (RR): only ch3 and ch1 valid, `ptr` = 3 → ch3 is granted, then ch1; `ptr` = 2 afterwards.
- Fixed mode: ch2 and ch0 valid continuously → every output is from ch0; ch2 gets `up_ready` only after ch0 drops valid.
- Backpressure: `down_ready` = 0 for 5 cycles with `down_valid` = 1 (data 0xA5, chan 1) → `down_*` stable, `up_ready` = 0, `ptr` unchanged; on release, the next word loads in the same edge.
- Idle gap: all `up_valid` = 0 after one transfer → `down_valid` falls one cycle after the last downstream transfer, and `down_data` holds its last value.
